// File: rtl/wb_regfile.sv
// Writeback stage merged with the 32-entry integer register file.
// Selects and commits writeback data, serves two bypassed read ports, counts retires, emits a commit trace.
module wb_regfile #(
    parameter int XLEN   = 32,
    parameter int CNT_W  = 64,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stop,
    input  logic [1:0]       WB_WdSel_i,
    input  logic             WB_RFwe_i,
    input  logic [XLEN-1:0]  WB_pc4_i,
    input  logic [XLEN-1:0]  WB_ALUc_i,
    input  logic [XLEN-1:0]  WB_DMdata_i,
    input  logic [XLEN-1:0]  WB_imm_i,
    input  logic [4:0]       WB_rd_i,
    input  logic [31:0]      WB_inst_i,
    input  logic             WB_IDstop_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    output logic [XLEN-1:0]  rd1_o,
    output logic [XLEN-1:0]  rd2_o,
    output logic [XLEN-1:0]  wb_wdata_o,
    output logic             wb_we_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic             trace_valid_o,
    output logic [XLEN-1:0]  trace_pc_o,
    output logic [31:0]      trace_inst_o,
    output logic [4:0]       trace_rd_o,
    output logic [XLEN-1:0]  trace_wdata_o
);

    // x0 has no storage; reads of address 0 are forced to zero below.
    logic [XLEN-1:0] regs [1:31];
    logic            commit;

    always_comb begin
        case (WB_WdSel_i)
            2'b00:   wb_wdata_o = WB_ALUc_i;
            2'b01:   wb_wdata_o = WB_DMdata_i;
            2'b10:   wb_wdata_o = WB_pc4_i;
            default: wb_wdata_o = WB_imm_i;
        endcase
    end

    assign wb_we_o = WB_RFwe_i & ~stop & ~WB_IDstop_i & (WB_rd_i != 5'd0);
    assign commit  = ~stop & ~WB_IDstop_i & (WB_inst_i != 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else if (wb_we_o) begin
            regs[WB_rd_i] <= wb_wdata_o;
        end
    end

    // Write-first: a same-cycle write to the addressed register wins over the array.
    always_comb begin
        rd1_o = '0;
        if (rs1_i != 5'd0) begin
            if (BYPASS && wb_we_o && (rs1_i == WB_rd_i)) rd1_o = wb_wdata_o;
            else                                         rd1_o = regs[rs1_i];
        end
    end

    always_comb begin
        rd2_o = '0;
        if (rs2_i != 5'd0) begin
            if (BYPASS && wb_we_o && (rs2_i == WB_rd_i)) rd2_o = wb_wdata_o;
            else                                         rd2_o = regs[rs2_i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_o  <= '0;
            trace_valid_o <= 1'b0;
            trace_pc_o    <= '0;
            trace_inst_o  <= '0;
            trace_rd_o    <= '0;
            trace_wdata_o <= '0;
        end else if (commit) begin
            retire_cnt_o  <= retire_cnt_o + 1'b1;
            trace_valid_o <= 1'b1;
            trace_pc_o    <= WB_pc4_i - XLEN'(4);
            trace_inst_o  <= WB_inst_i;
            trace_rd_o    <= wb_we_o ? WB_rd_i : 5'd0;
            trace_wdata_o <= wb_we_o ? wb_wdata_o : '0;
        end else begin
            trace_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a bypassing and a non-bypassing instance (CNT_W = 4) checked
// every cycle against an array/arithmetic model, plus hand-computed directed expectations.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stop, rf_we, idstop;
    logic [1:0]  wd_sel;
    logic [31:0] pc4, aluc, dmdata, imm, inst;
    logic [4:0]  rd, rs1, rs2;

    logic [31:0] b_rd1, b_rd2, b_wdata, b_tpc, b_tinst, b_twd;
    logic        b_we, b_tv;
    logic [3:0]  b_cnt;
    logic [4:0]  b_trd;
    logic [31:0] n_rd1, n_rd2, n_wdata, n_tpc, n_tinst, n_twd;
    logic        n_we, n_tv;
    logic [3:0]  n_cnt;
    logic [4:0]  n_trd;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    wb_regfile #(.XLEN(32), .CNT_W(4), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stop(stop), .WB_WdSel_i(wd_sel), .WB_RFwe_i(rf_we),
        .WB_pc4_i(pc4), .WB_ALUc_i(aluc), .WB_DMdata_i(dmdata), .WB_imm_i(imm),
        .WB_rd_i(rd), .WB_inst_i(inst), .WB_IDstop_i(idstop), .rs1_i(rs1), .rs2_i(rs2),
        .rd1_o(b_rd1), .rd2_o(b_rd2), .wb_wdata_o(b_wdata), .wb_we_o(b_we),
        .retire_cnt_o(b_cnt), .trace_valid_o(b_tv), .trace_pc_o(b_tpc),
        .trace_inst_o(b_tinst), .trace_rd_o(b_trd), .trace_wdata_o(b_twd)
    );

    wb_regfile #(.XLEN(32), .CNT_W(4), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .stop(stop), .WB_WdSel_i(wd_sel), .WB_RFwe_i(rf_we),
        .WB_pc4_i(pc4), .WB_ALUc_i(aluc), .WB_DMdata_i(dmdata), .WB_imm_i(imm),
        .WB_rd_i(rd), .WB_inst_i(inst), .WB_IDstop_i(idstop), .rs1_i(rs1), .rs2_i(rs2),
        .rd1_o(n_rd1), .rd2_o(n_rd2), .wb_wdata_o(n_wdata), .wb_we_o(n_we),
        .retire_cnt_o(n_cnt), .trace_valid_o(n_tv), .trace_pc_o(n_tpc),
        .trace_inst_o(n_tinst), .trace_rd_o(n_trd), .trace_wdata_o(n_twd)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    int          m_cnt = 0;
    logic        t_v = 0;
    logic [31:0] t_pc = 0, t_inst = 0, t_wd = 0;
    logic [4:0]  t_rd = 0;

    initial for (int i = 0; i < 32; i++) m_regs[i] = 0;

    function automatic logic [31:0] m_wdata();
        logic [31:0] src [4];
        src[0] = aluc; src[1] = dmdata; src[2] = pc4; src[3] = imm;
        return src[wd_sel];
    endfunction

    function automatic logic m_we();
        return rf_we && !stop && !idstop && rd != 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] rs, input bit byp);
        if (rs == 0) return 0;
        if (byp && m_we() && rs == rd) return m_wdata();
        return m_regs[rs];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            m_cnt = 0; t_v = 0; t_pc = 0; t_inst = 0; t_rd = 0; t_wd = 0;
        end else begin
            logic        w;
            logic [31:0] d;
            w = m_we();
            d = m_wdata();
            if (!stop && !idstop && inst != 0) begin
                m_cnt  = (m_cnt + 1) % 16;
                t_v    = 1;
                t_pc   = pc4 - 32'd4;
                t_inst = inst;
                t_rd   = w ? rd : 5'd0;
                t_wd   = w ? d : 32'd0;
            end else begin
                t_v = 0;
            end
            if (w) m_regs[rd] = d;
        end
    end

    always @(negedge clk) begin
        chk("wdata", b_wdata, m_wdata());
        chk("we", b_we, m_we());
        chk("rd1", b_rd1, m_read(rs1, 1));
        chk("rd2", b_rd2, m_read(rs2, 1));
        chk("nb_rd1", n_rd1, m_read(rs1, 0));
        chk("nb_rd2", n_rd2, m_read(rs2, 0));
        chk("cnt", b_cnt, m_cnt);
        chk("nb_cnt", n_cnt, m_cnt);
        chk("tvalid", b_tv, t_v);
        chk("tpc", b_tpc, t_pc);
        chk("tinst", b_tinst, t_inst);
        chk("trd", b_trd, t_rd);
        chk("twdata", b_twd, t_wd);
    end

    // ---------------- directed stimulus ----------------
    task automatic half();
        @(negedge clk); #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    logic [31:0] vals [4];
    logic [3:0]  c0;

    initial begin
        rst_n = 0; stop = 0; rf_we = 0; idstop = 0; wd_sel = 0;
        pc4 = 0; aluc = 0; dmdata = 0; imm = 0; inst = 0; rd = 0; rs1 = 0; rs2 = 0;
        repeat (2) step();
        half();
        chk("rst_cnt", b_cnt, 0);
        chk("rst_tvalid", b_tv, 0);
        chk("rst_tpc", b_tpc, 0);
        rst_n = 1;
        step();

        // mux sweep into x5
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
        aluc = 32'h11; dmdata = 32'h22; pc4 = 32'h33; imm = 32'h44;
        rf_we = 1; rd = 5; rs1 = 5; rs2 = 0; inst = 32'h00a00293;
        for (int s = 0; s < 4; s++) begin
            wd_sel = 2'(s);
            half();
            chk("sweep_byp", b_rd1, vals[s]);
            if (s > 0) chk("sweep_nb", n_rd1, vals[s-1]);
            step();
        end
        rf_we = 0;
        half();
        chk("sweep_final", n_rd1, 32'h44);
        chk("sweep_cnt", b_cnt, 4);
        step();

        // same-cycle bypass on both ports
        wd_sel = 0; aluc = 32'hDEADBEEF; rf_we = 1; rd = 7; rs1 = 7; rs2 = 7; pc4 = 32'h200;
        half();
        chk("byp_rd1", b_rd1, 32'hDEADBEEF);
        chk("byp_rd2", b_rd2, 32'hDEADBEEF);
        chk("nb_old", n_rd1, 0);
        step();
        rf_we = 0;
        half();
        chk("nb_new", n_rd2, 32'hDEADBEEF);
        step();

        // write to x0 still commits
        c0 = b_cnt;
        rf_we = 1; rd = 0; aluc = 32'hFFFFFFFF; rs1 = 0; pc4 = 32'h208;
        half();
        chk("x0_we", b_we, 0);
        chk("x0_rd", b_rd1, 0);
        step();
        half();
        chk("x0_cnt", b_cnt, c0 + 4'd1);
        chk("x0_tv", b_tv, 1);
        chk("x0_trd", b_trd, 0);
        chk("x0_twd", b_twd, 0);

        // stall holds one instruction for 3 cycles
        c0 = b_cnt;
        stop = 1; inst = 32'h00500093; pc4 = 32'h104; aluc = 5; wd_sel = 0; rd = 1; rs1 = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            half();
            chk("stall_tv", b_tv, 0);
            chk("stall_cnt", b_cnt, c0);
        end
        stop = 0;
        step();
        half();
        chk("rel_cnt", b_cnt, c0 + 4'd1);
        chk("rel_tv", b_tv, 1);
        chk("rel_tpc", b_tpc, 32'h100);
        chk("rel_trd", b_trd, 1);
        chk("rel_twd", b_twd, 5);
        chk("rel_x1", b_rd1, 5);
        inst = 0;
        step();
        half();
        chk("rel_once", b_cnt, c0 + 4'd1);

        // bubbles: stall-inserted slot and zero instruction
        c0 = b_cnt;
        idstop = 1; inst = 32'h00300193; rd = 3; rf_we = 1; aluc = 32'h77; rs1 = 3;
        step();
        idstop = 0; inst = 0;
        half();
        chk("bub_tv", b_tv, 0);
        step();
        half();
        chk("bub_cnt", b_cnt, c0);
        chk("bub_tv0", b_tv, 0);

        // counter wrap 15 -> 0
        rf_we = 0; inst = 32'h00000013; pc4 = 32'h0;
        for (int i = 0; i < 17 && b_cnt != 4'd15; i++) step();
        half();
        chk("pre_wrap", b_cnt, 15);
        chk("wrap_tpc", b_tpc, 32'hFFFFFFFC);
        step();
        half();
        chk("wrap", b_cnt, 0);

        // asynchronous reset mid-run
        inst = 0; rs1 = 5; rs2 = 7;
        step();
        half();
        rst_n = 0;
        #1;
        chk("mrst_x5", b_rd1, 0);
        chk("mrst_x7", b_rd2, 0);
        chk("mrst_cnt", b_cnt, 0);
        chk("mrst_tv", b_tv, 0);
        step();
        rst_n = 1;
        inst = 32'h00000013; pc4 = 32'h404;
        step();
        inst = 0;
        half();
        chk("post_rst_cnt", b_cnt, 1);
        chk("post_rst_tpc", b_tpc, 32'h400);
        step();
        half();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
